// File: rtl/bcd_7seg_scan.sv
// Time-multiplexed multi-digit BCD to 7-segment scanner with shadowed digit capture.
// Optional leading-zero blanking: define BCD_7SEG_SCAN_LZ_BLANK_EN.
module bcd_7seg_scan #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam logic [6:0]            SEG_BLANK = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{AN_ACTIVE_LOW}};

    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [NUM_DIGITS-1:0]   r_dp_shadow;
    logic [DIV_W-1:0]        r_div_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_frame_done;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;

    logic                    w_div_tc;
    logic                    w_idx_last;
    logic [3:0]              w_digit;
    logic [6:0]              w_seg_ah;
    logic [NUM_DIGITS-1:0]   w_onehot;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        case (d)
            4'd0:    f_decode = 7'b1111110;
            4'd1:    f_decode = 7'b0110000;
            4'd2:    f_decode = 7'b1101101;
            4'd3:    f_decode = 7'b1111001;
            4'd4:    f_decode = 7'b0110011;
            4'd5:    f_decode = 7'b1011011;
            4'd6:    f_decode = 7'b1011111;
            4'd7:    f_decode = 7'b1110000;
            4'd8:    f_decode = 7'b1111111;
            4'd9:    f_decode = 7'b1111011;
            default: f_decode = 7'b0000000;
        endcase
    endfunction

    // NOTE: the shadow is a handful of flops rather than a RAM, so it takes the async reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow    <= '0;
            r_dp_shadow <= '0;
        end else if (load) begin
            r_shadow    <= bcd_in;
            r_dp_shadow <= dp_in;
        end
    end

    assign w_div_tc   = (r_div_cnt == DIV_W'(REFRESH_DIV - 1));
    assign w_idx_last = (r_idx == IDX_W'(NUM_DIGITS - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt    <= '0;
            r_idx        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= en && w_div_tc && w_idx_last;
            if (en) begin
                if (w_div_tc) begin
                    r_div_cnt <= '0;
                    r_idx     <= w_idx_last ? '0 : r_idx + 1'b1;
                end else begin
                    r_div_cnt <= r_div_cnt + 1'b1;
                end
            end
        end
    end

`ifdef BCD_7SEG_SCAN_LZ_BLANK_EN
    logic [IDX_W-1:0] w_msd;

    // NOTE: w_msd gets a default before the loop, so no latch is inferred.
    always_comb begin
        w_msd = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (r_shadow[4*i +: 4] != 4'd0) w_msd = IDX_W'(i);
        end
    end
`endif

    always_comb begin
        w_digit  = r_shadow[{r_idx, 2'b00} +: 4];
        w_seg_ah = f_decode(w_digit);
`ifdef BCD_7SEG_SCAN_LZ_BLANK_EN
        // Digit 0 can never exceed w_msd, so it is always shown.
        if (r_idx > w_msd) w_seg_ah = 7'b0000000;
`endif
    end

    assign w_onehot = NUM_DIGITS'(1) << r_idx;

    // One cycle of latency: outputs reflect the idx/shadow held before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= SEG_BLANK;
            r_dp  <= SEG_ACTIVE_LOW;
            r_an  <= AN_OFF;
        end else if (en) begin
            r_seg <= w_seg_ah ^ SEG_BLANK;
            r_dp  <= r_dp_shadow[r_idx] ^ SEG_ACTIVE_LOW;
            r_an  <= w_onehot ^ AN_OFF;
        end else begin
            r_seg <= SEG_BLANK;
            r_dp  <= SEG_ACTIVE_LOW;
            r_an  <= AN_OFF;
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule
